// File: rtl/gray_code_pkg.sv
// Shared Gray-code helpers used by both the counter (encode) and receiver (decode) sides.
// Functions work on a maximum-width word; narrower counts are zero-extended, which leaves both conversions exact.
package gray_code_pkg;

    localparam int unsigned GRAY_MAX_W = 32;

    typedef logic [GRAY_MAX_W-1:0] gray_word_t;

    function automatic gray_word_t bin2gray(input gray_word_t bin);
        return bin ^ (bin >> 1);
    endfunction

    // Each binary bit is the XOR of all Gray bits at or above it; zero upper bits are neutral.
    function automatic gray_word_t gray2bin(input gray_word_t gray);
        gray_word_t bin;
        bin = '0;
        bin[GRAY_MAX_W-1] = gray[GRAY_MAX_W-1];
        for (int unsigned i = GRAY_MAX_W - 1; i > 0; i--) begin
            bin[i-1] = bin[i] ^ gray[i-1];
        end
        return bin;
    endfunction

endpackage

// File: rtl/gray_code_sync.sv
// Plain flop chain that resynchronizes a Gray count into the local clock domain.
// No logic between stages so synthesis attributes for metastability hardening apply cleanly.
module gray_code_sync #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] chain [SYNC_STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                chain[i] <= '0;
            end
        end else begin
            chain[0] <= d;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                chain[i] <= chain[i-1];
            end
        end
    end

    assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/gray_code_receiver.sv
// Receive side of a Gray-coded count crossing: synchronize, decode to binary,
// report the increment since the last accepted value and flag illegal transitions.
module gray_code_receiver
    import gray_code_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] gray_i,
    input  logic             ce_i,
    input  logic             clr_err_i,
    output logic [WIDTH-1:0] gray_o,
    output logic [WIDTH-1:0] binary_o,
    output logic [WIDTH-1:0] delta_o,
    output logic             update_o,
    output logic             error_o
);

    logic [WIDTH-1:0] gray_s;
    logic [WIDTH-1:0] bin_s;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] gray_q;
    logic [WIDTH-1:0] binary_q;
    logic [WIDTH-1:0] delta_q;
    logic             update_q;
    logic             error_q;
    logic             cont_q;
    logic             changed;
    logic             illegal;

    gray_code_sync #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .d     (gray_i),
        .q     (gray_s)
    );

    // A legal +1 step is always a single-bit change, so any other changed value is illegal.
    always_comb begin
        bin_s   = WIDTH'(gray2bin(GRAY_MAX_W'(gray_s)));
        diff    = bin_s - binary_q;
        changed = (gray_s != gray_q);
        illegal = 1'b0;
        if (ce_i && cont_q) begin
            if ($countones(gray_s ^ gray_q) > 1) begin
                illegal = 1'b1;
            end else if (changed && (diff != WIDTH'(1))) begin
                illegal = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            gray_q   <= '0;
            binary_q <= '0;
            delta_q  <= '0;
            update_q <= 1'b0;
            error_q  <= 1'b0;
            cont_q   <= 1'b0;
        end else begin
            cont_q <= ce_i;
            if (ce_i) begin
                gray_q   <= gray_s;
                binary_q <= bin_s;
                update_q <= changed;
                if (changed) begin
                    delta_q <= diff;
                end
            end else begin
                update_q <= 1'b0;
            end
            if (illegal) begin
                error_q <= 1'b1;
            end else if (clr_err_i) begin
                error_q <= 1'b0;
            end
        end
    end

    assign gray_o   = gray_q;
    assign binary_o = binary_q;
    assign delta_o  = delta_q;
    assign update_o = update_q;
    assign error_o  = error_q;

endmodule

// File: tb/tb_gray_code_receiver.sv
// Self-checking bench for gray_code_receiver (WIDTH=8, SYNC_STAGES=2) against a count-level reference model.
module tb_gray_code_receiver;

    logic       clk_i;
    logic       rst_ni;
    logic [7:0] gray_i;
    logic       ce_i;
    logic       clr_err_i;
    logic [7:0] gray_o;
    logic [7:0] binary_o;
    logic [7:0] delta_o;
    logic       update_o;
    logic       error_o;

    int errors;
    int checks;

    // Reference model state: values as seen at the outputs after each edge.
    logic [7:0] m_gray;
    logic [7:0] m_bin;
    logic [7:0] m_delta;
    logic       m_upd;
    logic       m_err;
    logic       m_cont;
    logic [7:0] lat_q [$];

    gray_code_receiver #(
        .WIDTH       (8),
        .SYNC_STAGES (2)
    ) dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .gray_i    (gray_i),
        .ce_i      (ce_i),
        .clr_err_i (clr_err_i),
        .gray_o    (gray_o),
        .binary_o  (binary_o),
        .delta_o   (delta_o),
        .update_o  (update_o),
        .error_o   (error_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    function automatic logic [7:0] enc(input int v);
        return 8'((v ^ (v >> 1)) & 255);
    endfunction

    // Decode by searching the code table for the count that encodes to g.
    function automatic int decode(input logic [7:0] g);
        for (int v = 0; v < 256; v++) begin
            if (enc(v) == g) return v;
        end
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "/gray"},   gray_o,          m_gray);
        chk({tag, "/binary"}, binary_o,        m_bin);
        chk({tag, "/delta"},  delta_o,         m_delta);
        chk({tag, "/update"}, 8'(update_o),    8'(m_upd));
        chk({tag, "/error"},  8'(error_o),     8'(m_err));
    endtask

    task automatic model_reset();
        lat_q   = '{8'h00, 8'h00};
        m_gray  = '0;
        m_bin   = '0;
        m_delta = '0;
        m_upd   = 1'b0;
        m_err   = 1'b0;
        m_cont  = 1'b0;
    endtask

    // gray_i sampled at an edge is acted on two edges later.
    task automatic model_edge(input logic [7:0] g_in, input logic c, input logic cl);
        logic [7:0] gs;
        int b;
        int d;
        logic set;
        gs  = lat_q.pop_front();
        lat_q.push_back(g_in);
        set = 1'b0;
        if (c) begin
            b = decode(gs);
            if (gs != m_gray) begin
                d = (b - int'(m_bin) + 256) % 256;
                m_upd   = 1'b1;
                m_delta = 8'(d);
                if (m_cont && d != 1) set = 1'b1;
            end else begin
                m_upd = 1'b0;
            end
            m_gray = gs;
            m_bin  = 8'(b);
        end else begin
            m_upd = 1'b0;
        end
        if (set) m_err = 1'b1;
        else if (cl) m_err = 1'b0;
        m_cont = c;
    endtask

    task automatic step(input logic [7:0] g, input logic c, input logic cl, input string tag);
        gray_i    = g;
        ce_i      = c;
        clr_err_i = cl;
        @(posedge clk_i);
        model_edge(g, c, cl);
        #1;
        check_all(tag);
    endtask

    // Asynchronous reset pulse placed between clock edges; outputs must clear before the next edge.
    task automatic async_reset(input string tag);
        #3;
        rst_ni = 1'b0;
        model_reset();
        #1;
        check_all(tag);
        #1;
        rst_ni = 1'b1;
    endtask

    initial begin
        int upd_count;
        int cur;
        logic [7:0] g;
        errors    = 0;
        checks    = 0;
        rst_ni    = 1'b0;
        gray_i    = 8'h5A;
        ce_i      = 1'b1;
        clr_err_i = 1'b0;
        model_reset();

        // Reset held with a nonzero input
        repeat (3) @(posedge clk_i);
        #1;
        check_all("reset_hold");
        gray_i = 8'h00;
        #2;
        rst_ni = 1'b1;
        repeat (10) step(8'h00, 1'b1, 1'b0, "post_reset_idle");

        // Single step 0x00 -> 0x01
        step(8'h01, 1'b1, 1'b0, "single0");
        step(8'h01, 1'b1, 1'b0, "single1");
        step(8'h01, 1'b1, 1'b0, "single2");
        chk("single_update", 8'(update_o), 8'h01);
        chk("single_binary", binary_o, 8'h01);
        chk("single_delta",  delta_o,  8'h01);
        step(8'h01, 1'b1, 1'b0, "single3");
        chk("single_pulse_end", 8'(update_o), 8'h00);

        // Full sweep through all codes including the wrap
        upd_count = 0;
        for (int k = 2; k <= 257; k++) begin
            for (int r = 0; r < 4; r++) begin
                step(enc(k % 256), 1'b1, 1'b0, "sweep");
                if (update_o === 1'b1) upd_count++;
            end
        end
        chk("sweep_updates", 8'(upd_count / 2), 8'(128));
        chk("sweep_update_total_lsb", 8'(upd_count % 256), 8'h00);
        chk("sweep_error", 8'(error_o), 8'h00);

        // Multi-bit jump 0x00 -> 0x03 is sticky, clear works, clear loses to a new jump
        async_reset("reset_before_jump");
        repeat (4) step(8'h00, 1'b1, 1'b0, "jump_idle");
        repeat (4) step(8'h03, 1'b1, 1'b0, "jump");
        chk("jump_binary", binary_o, 8'h02);
        chk("jump_delta",  delta_o,  8'h02);
        chk("jump_error",  8'(error_o), 8'h01);
        step(8'h03, 1'b1, 1'b1, "clr_alone");
        chk("clr_alone_error", 8'(error_o), 8'h00);
        step(8'h0C, 1'b1, 1'b0, "jump2_a");
        step(8'h0C, 1'b1, 1'b0, "jump2_b");
        step(8'h0C, 1'b1, 1'b1, "jump2_clr");
        chk("clr_vs_set_error", 8'(error_o), 8'h01);
        step(8'h0C, 1'b1, 1'b0, "jump2_hold");

        // Enable gap: stale compare accepts the full gap without error
        async_reset("reset_before_gap");
        repeat (3) step(8'h00, 1'b1, 1'b0, "gap_idle");
        repeat (4) step(8'h01, 1'b1, 1'b0, "gap_start");
        repeat (3) step(8'h03, 1'b0, 1'b0, "gap_walk");
        repeat (3) step(8'h02, 1'b0, 1'b0, "gap_walk");
        repeat (4) step(8'h06, 1'b0, 1'b0, "gap_walk");
        upd_count = 0;
        step(8'h06, 1'b1, 1'b0, "gap_resume");
        chk("gap_delta", delta_o, 8'h03);
        chk("gap_error", 8'(error_o), 8'h00);
        if (update_o === 1'b1) upd_count++;
        repeat (3) begin
            step(8'h06, 1'b1, 1'b0, "gap_after");
            if (update_o === 1'b1) upd_count++;
        end
        chk("gap_update_count", 8'(upd_count), 8'h01);

        // Backward step 0x07 -> 0x06, then asynchronous reset mid-stream
        repeat (4) step(8'h07, 1'b1, 1'b0, "back_fwd");
        repeat (3) step(8'h06, 1'b1, 1'b0, "back");
        chk("back_delta", delta_o, 8'hFF);
        chk("back_error", 8'(error_o), 8'h01);
        async_reset("reset_midstream");
        chk("reset_mid_error", 8'(error_o), 8'h00);
        repeat (3) step(8'h00, 1'b1, 1'b0, "post_mid_reset");

        // Randomized mix of legal walks, random jumps, enable gaps and clears
        cur = 0;
        for (int n = 0; n < 400; n++) begin
            int sel;
            sel = int'($urandom_range(0, 9));
            if (sel < 6) begin
                cur = (cur + 1) % 256;
                g   = enc(cur);
            end else if (sel < 8) begin
                g = gray_i;
            end else begin
                cur = int'($urandom_range(0, 255));
                g   = enc(cur);
            end
            step(g, ($urandom_range(0, 9) < 8), ($urandom_range(0, 9) == 0), "random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL timeout observed=running expected=finished");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
